// File: rtl/serial_bit_source_if.sv
// serial_bit_source_if: load handshake plus serial bit stream of serial_bit_source.
//   load_data  : parallel word to serialise
//   load_valid : load_data is valid
//   load_ready : source can accept a word this cycle
//   ser_out    : serial bit stream
//   bit_valid  : ser_out carries a frame bit
//   bit_cnt    : index of the bit on ser_out (0 = first bit sent)
//   frame_done : high during the last bit of a frame
// master = word producer / bit consumer side, slave = serial_bit_source itself.
interface serial_bit_source_if #(
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             bit_valid;
    logic [CntW-1:0]  bit_cnt;
    logic             frame_done;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  ser_out,
        input  bit_valid,
        input  bit_cnt,
        input  frame_done
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output ser_out,
        output bit_valid,
        output bit_cnt,
        output frame_done
    );
endinterface

// File: rtl/serial_bit_source.sv
// serial_bit_source: parallel-in/serial-out bit source. Accepts one WIDTH-bit word per
// load_valid/load_ready handshake and shifts it out one bit per clk, followed by
// GAP_CYCLES idle cycles. ser_out, bit_valid, bit_cnt and frame_done are registered;
// load_ready is the only combinational output.
// Ports:
//   clk : rising-edge clock
//   res : asynchronous reset, active-high
//   bus : serial_bit_source_if slave modport (load handshake and serial outputs)
module serial_bit_source #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP_CYCLES = 1,
    parameter bit          IDLE_LVL   = 1'b0
) (
    input logic                clk,
    input logic                res,
    serial_bit_source_if.slave bus
);
    localparam int unsigned CntW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned GapW    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic             ser_q, ser_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    // The bit currently on ser_out always sits at the outgoing end of shift_q
    // (top for MSB-first, bottom for LSB-first), so the next bit is its neighbour.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = '0;
        gap_d   = gap_q;
        ser_d   = IDLE_LVL;
        valid_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.load_valid) begin
                    state_d = StShift;
                    shift_d = bus.load_data;
                    ser_d   = MSB_FIRST ? bus.load_data[WIDTH-1] : bus.load_data[0];
                    valid_d = 1'b1;
                end
            end
            StShift: begin
                if (cnt_q == CntLast) begin
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? StGap : StIdle;
                end else begin
                    cnt_d   = cnt_q + CntW'(1);
                    shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                    ser_d   = MSB_FIRST ? shift_q[WIDTH-2] : shift_q[1];
                    valid_d = 1'b1;
                    done_d  = (cnt_d == CntLast);
                end
            end
            StGap: begin
                if (gap_q == GapW'(GapLast)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            ser_q   <= IDLE_LVL;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            ser_q   <= ser_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.load_ready = (state_q == StIdle) & ~res;
    assign bus.ser_out    = ser_q;
    assign bus.bit_valid  = valid_q;
    assign bus.bit_cnt    = cnt_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source: two instances (a: MSB-first, 1 gap cycle, idle 0;
// b: LSB-first, no gap, idle 1) checked every negedge against a frame-position model,
// plus directed frames with hand-computed expectations.
module tb_serial_bit_source;
    localparam int W = 8;

    bit msb_c[2]  = '{1'b1, 1'b0};
    int gap_c[2]  = '{1, 0};
    bit idle_c[2] = '{1'b0, 1'b1};

    logic clk = 1'b0;
    logic res = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    logic [7:0] data_v[2];
    logic       valid_v[2];
    logic       ready_w[2];
    logic       ser_w[2];
    logic       bv_w[2];
    logic       fd_w[2];
    logic [2:0] cnt_w[2];

    serial_bit_source_if #(.WIDTH(W)) bus_a ();
    serial_bit_source_if #(.WIDTH(W)) bus_b ();

    assign bus_a.load_data  = data_v[0];
    assign bus_a.load_valid = valid_v[0];
    assign bus_b.load_data  = data_v[1];
    assign bus_b.load_valid = valid_v[1];
    assign ready_w[0] = bus_a.load_ready;
    assign ser_w[0]   = bus_a.ser_out;
    assign bv_w[0]    = bus_a.bit_valid;
    assign fd_w[0]    = bus_a.frame_done;
    assign cnt_w[0]   = bus_a.bit_cnt;
    assign ready_w[1] = bus_b.load_ready;
    assign ser_w[1]   = bus_b.ser_out;
    assign bv_w[1]    = bus_b.bit_valid;
    assign fd_w[1]    = bus_b.frame_done;
    assign cnt_w[1]   = bus_b.bit_cnt;

    serial_bit_source #(
        .WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(1), .IDLE_LVL(1'b0)
    ) dut_a (
        .clk(clk),
        .res(res),
        .bus(bus_a)
    );

    serial_bit_source #(
        .WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LVL(1'b1)
    ) dut_b (
        .clk(clk),
        .res(res),
        .bus(bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Model: t_m = edges since the accept edge (1000 = never accepted / reset).
    // Bits occupy t = 0..W-1, gap t = W..W+gap-1, ready once t >= W+gap.
    int         t_m[2] = '{1000, 1000};
    logic [7:0] word_m[2];

    always @(posedge clk or posedge res) begin
        for (int k = 0; k < 2; k++) begin
            if (res) begin
                t_m[k] = 1000;
            end else if (t_m[k] >= W + gap_c[k]) begin
                if (valid_v[k]) begin
                    word_m[k] = data_v[k];
                    t_m[k]    = 0;
                end
            end else begin
                t_m[k]++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int         t;
        logic       e_ser, e_bv, e_fd, e_rdy;
        logic [2:0] e_cnt;
        for (int k = 0; k < 2; k++) begin
            t = t_m[k];
            if (t < W) begin
                e_bv  = 1'b1;
                e_cnt = 3'(t);
                e_fd  = (t == W - 1);
                e_ser = msb_c[k] ? word_m[k][W-1-t] : word_m[k][t];
            end else begin
                e_bv  = 1'b0;
                e_cnt = 3'd0;
                e_fd  = 1'b0;
                e_ser = idle_c[k];
            end
            e_rdy = !res && (t >= W + gap_c[k]);
            chk(k == 0 ? "a_ser_out" : "b_ser_out", ser_w[k], e_ser);
            chk(k == 0 ? "a_bit_valid" : "b_bit_valid", bv_w[k], e_bv);
            chk(k == 0 ? "a_bit_cnt" : "b_bit_cnt", cnt_w[k], e_cnt);
            chk(k == 0 ? "a_frame_done" : "b_frame_done", fd_w[k], e_fd);
            chk(k == 0 ? "a_load_ready" : "b_load_ready", ready_w[k], e_rdy);
        end
    end

    // Waits (bounded) for ready, presents one word for one edge; returns accept cycle.
    task automatic load_word(input int k, input logic [7:0] w, output int acc);
        int n = 0;
        while (!ready_w[k] && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("load_ready_wait", ready_w[k], 1);
        data_v[k]  = w;
        valid_v[k] = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        #1;
        valid_v[k] = 1'b0;
    endtask

    // Records W frame bits as seen at negedge; first bit ends up in got[7].
    task automatic collect(input int k, output logic [7:0] got, output int ndone);
        int n = 0;
        got   = '0;
        ndone = 0;
        for (int c = 0; c < 40 && n < W; c++) begin
            @(negedge clk);
            if (bv_w[k]) begin
                got = {got[6:0], ser_w[k]};
                ndone += int'(fd_w[k]);
                n++;
            end
        end
        chk("collect_bits_seen", n, W);
    endtask

    initial begin
        int         a1, a2, nd, det;
        logic [7:0] got;
        int         acc_a[$];
        int         acc_b[$];

        data_v  = '{8'h00, 8'h00};
        valid_v = '{1'b0, 1'b0};
        res     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_a", ready_w[0], 0);
        chk("rst_valid_a", bv_w[0], 0);
        chk("rst_ser_a", ser_w[0], 0);
        chk("rst_ser_b", ser_w[1], 1);
        chk("rst_cnt_b", cnt_w[1], 0);
        res = 1'b0;
        #1;
        chk("ready_after_rst", ready_w[0], 1);
        @(posedge clk);
        #2;

        // MSB-first 8'hA5 with one gap cycle, then spacing to the next accept.
        load_word(0, 8'hA5, a1);
        collect(0, got, nd);
        chk("a5_bits", got, 8'hA5);
        chk("a5_frame_done_count", nd, 1);
        det = 0;
        for (int i = 0; i < 6; i++) begin
            if ({got[7-i], got[6-i], got[5-i]} == 3'b101) det++;
        end
        chk("a5_det101", det, 2);
        @(posedge clk);
        #1;
        chk("a_gap_ready", ready_w[0], 0);
        chk("a_gap_ser", ser_w[0], 0);
        @(posedge clk);
        #1;
        chk("a_after_gap_ready", ready_w[0], 1);
        #1;
        load_word(0, 8'h5A, a2);
        chk("a_accept_spacing", a2 - a1, 10);
        collect(0, got, nd);
        chk("5a_bits", got, 8'h5A);

        // LSB-first single-bit words.
        load_word(1, 8'h01, a1);
        collect(1, got, nd);
        chk("b01_bits", got, 8'h80);
        load_word(1, 8'h80, a2);
        collect(1, got, nd);
        chk("b80_bits", got, 8'h01);
        chk("b80_frame_done_count", nd, 1);

        // No gap: back-to-back FF then 00.
        load_word(1, 8'hFF, a1);
        load_word(1, 8'h00, a2);
        chk("b_back_to_back_spacing", a2 - a1, 9);
        collect(1, got, nd);
        chk("b00_bits", got, 8'h00);

        // load_valid held high, data changing every cycle.
        @(posedge clk);
        #2;
        valid_v = '{1'b1, 1'b1};
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (ready_w[0]) acc_a.push_back(cyc);
            if (ready_w[1]) acc_b.push_back(cyc);
            @(posedge clk);
            #2;
            data_v[0] = 8'($urandom);
            data_v[1] = 8'($urandom);
        end
        valid_v = '{1'b0, 1'b0};
        chk("a_stream_accepts", acc_a.size() >= 3, 1);
        chk("b_stream_accepts", acc_b.size() >= 3, 1);
        for (int i = 1; i < acc_a.size(); i++) chk("a_stream_spacing", acc_a[i] - acc_a[i-1], 10);
        for (int i = 1; i < acc_b.size(); i++) chk("b_stream_spacing", acc_b[i] - acc_b[i-1], 9);

        // Asynchronous reset during bit 3, then a fresh frame.
        load_word(0, 8'hA5, a1);
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_bit_cnt", cnt_w[0], 3);
        res = 1'b1;
        #1;
        chk("mid_rst_ser", ser_w[0], 0);
        chk("mid_rst_valid", bv_w[0], 0);
        chk("mid_rst_cnt", cnt_w[0], 0);
        chk("mid_rst_done", fd_w[0], 0);
        chk("mid_rst_ready", ready_w[0], 0);
        @(posedge clk);
        #2;
        res = 1'b0;
        #1;
        chk("post_rst_ready", ready_w[0], 1);
        #1;
        load_word(0, 8'h3C, a2);
        collect(0, got, nd);
        chk("3c_bits", got, 8'h3C);
        chk("3c_frame_done_count", nd, 1);

        // Random traffic with occasional resets.
        @(posedge clk);
        #2;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                valid_v[k] = ($urandom_range(0, 3) != 0);
                data_v[k]  = 8'($urandom);
            end
            if ($urandom_range(0, 149) == 0) begin
                res = 1'b1;
                @(posedge clk);
                #2;
                res = 1'b0;
            end
            @(posedge clk);
            #2;
        end
        valid_v = '{1'b0, 1'b0};
        repeat (12) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
